// File: rtl/serial_to_parallel_block.sv
// serial_to_parallel_block
// Collects a byte-serial stream into one NBYTES-wide block (first byte in the
// most significant position). It has an assembly register and an output holding
// register. If the output slot is still occupied when a block completes, that
// block waits in the assembly register and stalls the input for one block.
module serial_to_parallel_block #(
  parameter int NBYTES = 16,
  parameter int CW     = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            serial_d_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic [CW-1:0]         byte_cnt
);

  localparam int              W    = 8 * NBYTES;
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

  logic [W-1:0]  asm_q,       asm_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          asm_full_q,  asm_full_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;

  logic          slot_free;
  logic          accept;
  logic [W-1:0]  shifted;

  // in_ready depends only on a register, so it has no combinational path from
  // in_valid or out_ready.
  assign in_ready  = !asm_full_q;
  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && !asm_full_q;
  assign shifted   = {asm_q[W-9:0], serial_d_in};

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign byte_cnt  = cnt_q;

  // Next-state logic: output handshake, drain of a held block, then byte
  // assembly or flush.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // this block can leave a signal unassigned and infer a latch.
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    asm_full_d  = asm_full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // The consumer takes the current block. out_data keeps its value.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A held block moves into the free output slot.
    if (asm_full_q && slot_free) begin
      out_data_d  = asm_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end

    if (clear) begin
      // Flush the partial block. Any byte offered this cycle is dropped.
      asm_d      = '0;
      cnt_d      = '0;
      asm_full_d = 1'b0;
    end else if (accept) begin
      // accept implies !asm_full_q, so this never overlaps with the drain above.
      asm_d = shifted;
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (slot_free) begin
          out_data_d  = shifted;
          out_valid_d = 1'b1;
        end else begin
          asm_full_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever order the statements are in.
    if (!rst) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      asm_full_q  <= asm_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
